// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU result path.
//   res_src_e      : encoding of the result source carried alongside each entry
//   CMP_OUT_WIDTH  : width of the compare unit result
//   DROP_CNT_WIDTH : width of the saturating lost-result counter
//   even_parity()  : parity bit that makes the total number of ones even
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {
    SRC_ARITH = 2'b00,
    SRC_LOGIC = 2'b01,
    SRC_CMP   = 2'b10,
    SRC_SHIFT = 2'b11
  } res_src_e;

  localparam int CMP_OUT_WIDTH  = 3;
  localparam int DROP_CNT_WIDTH = 8;

  // Even parity over a 64-bit-or-narrower vector (callers zero-extend).
  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// ---------------------------------------------------------------------------
// alu_res_fifo
// Generic synchronous first-word-fall-through FIFO.
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-high reset (empties the FIFO)
//   push_i   : write request; accepted when not full, or when full and a pop
//              happens on the same edge
//   wdata_i  : write data
//   pop_i    : read request; ignored while empty
//   rdata_o  : head entry, forced to zero while empty
//   valid_o  : FIFO is non-empty
//   full_o   : FIFO holds DEPTH entries
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module alu_res_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty ? '0 : mem_q[rd_ptr_q];
  assign valid_o = !empty;
  assign full_o  = full;

endmodule

// File: rtl/alu_result_collector.sv
// ---------------------------------------------------------------------------
// alu_result_collector
// Collects results from the arith/logic/shift/compare units into a FWFT FIFO.
//   CLK, RST              : clock and asynchronous active-high reset
//   Arith_OUT/Carry_OUT/Arith_Flag : arithmetic result, carry, valid
//   Logic_OUT/Logic_Flag  : logic result, valid
//   Shift_OUT/Shift_Flag  : shift result, valid
//   CMP_OUT/CMP_Flag      : compare result, valid
//   RES_DATA/RES_CARRY/RES_SRC : head entry (zero while empty)
//   RES_VALID/RES_READY   : valid/ready handshake. The head is transferred on
//                           every rising edge where both are high; the head
//                           holds steady while valid is high and ready is low.
//   FULL                  : FIFO holds DEPTH entries
//   DROP_CNT              : saturating count of results lost to a full FIFO
//   MULTI_ERR             : one-cycle pulse after an edge that saw >1 flag
//   RES_PARITY            : even parity of the head entry, only when the
//                           ALU_RESULT_PARITY_EN macro is defined
// ---------------------------------------------------------------------------
module alu_result_collector
  import alu_pkg::*;
#(
  parameter int OP_DATA_WIDTH = 16,
  parameter int DEPTH         = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [2*OP_DATA_WIDTH-1:0]   Arith_OUT,
  input  logic                         Carry_OUT,
  input  logic                         Arith_Flag,
  input  logic [OP_DATA_WIDTH-1:0]     Logic_OUT,
  input  logic                         Logic_Flag,
  input  logic [OP_DATA_WIDTH-1:0]     Shift_OUT,
  input  logic                         Shift_Flag,
  input  logic [CMP_OUT_WIDTH-1:0]     CMP_OUT,
  input  logic                         CMP_Flag,
  output logic [2*OP_DATA_WIDTH-1:0]   RES_DATA,
  output logic                         RES_CARRY,
  output logic [1:0]                   RES_SRC,
  output logic                         RES_VALID,
  input  logic                         RES_READY,
  output logic                         FULL,
  output logic [DROP_CNT_WIDTH-1:0]    DROP_CNT,
  output logic                         MULTI_ERR
`ifdef ALU_RESULT_PARITY_EN
  ,
  output logic                         RES_PARITY
`endif
);

  localparam int RES_W  = 2 * OP_DATA_WIDTH;
  localparam int BASE_W = RES_W + 3;        // {carry, src, data}
`ifdef ALU_RESULT_PARITY_EN
  localparam int ENTRY_W = BASE_W + 1;      // parity kept in the MSB
`else
  localparam int ENTRY_W = BASE_W;
`endif

  logic [3:0]               flag_vec;
  logic [2:0]               n_flags;
  logic                     one_flag, multi_flag;
  logic [RES_W-1:0]         fmt_data;
  res_src_e                 fmt_src;
  logic                     fmt_carry;
  logic [BASE_W-1:0]        fmt_base;
  logic [ENTRY_W-1:0]       push_entry, head_entry;
  logic                     pop, drop;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                     multi_err_q, multi_err_d;

  assign flag_vec   = {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag};
  assign n_flags    = 3'($countones(flag_vec));
  assign one_flag   = (n_flags == 3'd1);
  assign multi_flag = (n_flags > 3'd1);

  always_comb begin
    fmt_data  = '0;
    fmt_src   = SRC_ARITH;
    fmt_carry = 1'b0;
    if (Arith_Flag) begin
      fmt_data  = Arith_OUT;
      fmt_carry = Carry_OUT;
    end else if (Logic_Flag) begin
      fmt_data  = RES_W'(Logic_OUT);
      fmt_src   = SRC_LOGIC;
    end else if (CMP_Flag) begin
      fmt_data  = RES_W'(CMP_OUT);
      fmt_src   = SRC_CMP;
    end else if (Shift_Flag) begin
      fmt_data  = RES_W'(Shift_OUT);
      fmt_src   = SRC_SHIFT;
    end
  end

  assign fmt_base = {fmt_carry, fmt_src, fmt_data};
`ifdef ALU_RESULT_PARITY_EN
  assign push_entry = {even_parity(64'(fmt_base)), fmt_base};
`else
  assign push_entry = fmt_base;
`endif

  assign pop  = RES_VALID && RES_READY;
  // A single offered result is lost only when the FIFO cannot make room.
  assign drop = one_flag && FULL && !pop;

  always_comb begin
    drop_cnt_d  = drop_cnt_q;
    multi_err_d = multi_flag;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      drop_cnt_q  <= '0;
      multi_err_q <= 1'b0;
    end else begin
      drop_cnt_q  <= drop_cnt_d;
      multi_err_q <= multi_err_d;
    end
  end

  alu_res_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (one_flag),
    .wdata_i (push_entry),
    .pop_i   (RES_READY),
    .rdata_o (head_entry),
    .valid_o (RES_VALID),
    .full_o  (FULL)
  );

  assign RES_DATA  = head_entry[RES_W-1:0];
  assign RES_SRC   = head_entry[RES_W+1:RES_W];
  assign RES_CARRY = head_entry[RES_W+2];
`ifdef ALU_RESULT_PARITY_EN
  assign RES_PARITY = head_entry[ENTRY_W-1];
`endif
  assign DROP_CNT  = drop_cnt_q;
  assign MULTI_ERR = multi_err_q;

endmodule
